// File: rtl/riscv_alu_pkg.sv
// Shared ALU definitions: operation codes and shift-amount width helper.
package riscv_alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'h0,
        ALU_SUB    = 4'h1,
        ALU_AND    = 4'h2,
        ALU_OR     = 4'h3,
        ALU_XOR    = 4'h4,
        ALU_SLL    = 4'h5,
        ALU_SRL    = 4'h6,
        ALU_SRA    = 4'h7,
        ALU_SLT    = 4'h8,
        ALU_SLTU   = 4'h9,
        ALU_PASS_A = 4'hA,
        ALU_PASS_B = 4'hB,
        ALU_RSV_C  = 4'hC,
        ALU_RSV_D  = 4'hD,
        ALU_RSV_E  = 4'hE,
        ALU_RSV_F  = 4'hF
    } alu_op_e;

    // Number of low operand-b bits that form the shift amount.
    function automatic int unsigned ALU_SHAMT_W(input int unsigned xlen);
        return $clog2(xlen);
    endfunction

endpackage

// File: rtl/riscv_alu_core.sv
// Purely combinational integer ALU function; shared with the branch unit.
module riscv_alu_core
    import riscv_alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  alu_op_e         i_op,
    output logic [XLEN-1:0] o_result_c
);

    localparam int unsigned SHW = ALU_SHAMT_W(XLEN);

    logic [SHW-1:0] w_shamt;
    logic           w_lt;
    logic           w_ltu;

    assign w_shamt = i_b[SHW-1:0];
    assign w_lt    = $signed(i_a) < $signed(i_b);
    assign w_ltu   = i_a < i_b;

    // Reserved codes C-F fall through to pass-a.
    always_comb begin
        o_result_c = i_a;
        case (i_op)
            ALU_ADD:    o_result_c = i_a + i_b;
            ALU_SUB:    o_result_c = i_a - i_b;
            ALU_AND:    o_result_c = i_a & i_b;
            ALU_OR:     o_result_c = i_a | i_b;
            ALU_XOR:    o_result_c = i_a ^ i_b;
            ALU_SLL:    o_result_c = i_a << w_shamt;
            ALU_SRL:    o_result_c = i_a >> w_shamt;
            ALU_SRA:    o_result_c = XLEN'($signed(i_a) >>> w_shamt);
            ALU_SLT:    o_result_c = XLEN'(w_lt);
            ALU_SLTU:   o_result_c = XLEN'(w_ltu);
            ALU_PASS_A: o_result_c = i_a;
            ALU_PASS_B: o_result_c = i_b;
            default:    o_result_c = i_a;
        endcase
    end

endmodule

// File: rtl/riscv_alu_pipe.sv
// Elastic ALU pipeline: result computed into slot 0, then carried through
// STAGES valid/ready slots with bubble collapsing, flush and bypass taps.
module riscv_alu_pipe
    import riscv_alu_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 3,
    parameter int unsigned RW     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_rs1,
    input  logic [XLEN-1:0]      in_rs2,
    input  logic [XLEN-1:0]      in_imm,
    input  logic                 in_use_imm,
    input  logic [3:0]           in_alu_op,
    input  logic [RW-1:0]        in_rd,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_result,
    output logic [RW-1:0]        out_rd,
    output logic [STAGES-1:0]    byp_valid,
    output logic [STAGES*RW-1:0] byp_rd
);

    localparam int unsigned LAST = STAGES - 1;

    logic [XLEN-1:0]        w_b;
    logic [XLEN-1:0]        w_alu;
    logic                   w_accept;
    logic [STAGES-1:0]      w_valid;
    logic [STAGES-1:0]      w_adv;
    logic [STAGES-1:0]      w_load;
    logic [STAGES*XLEN-1:0] w_res_flat;

    assign w_b = in_use_imm ? in_imm : in_rs2;

    riscv_alu_core #(.XLEN(XLEN)) u_core (
        .i_a        (in_rs1),
        .i_b        (w_b),
        .i_op       (alu_op_e'(in_alu_op)),
        .o_result_c (w_alu)
    );

    // Advance chain from the output back towards slot 0: one AND/OR per slot.
    always_comb begin
        w_adv       = '0;
        w_adv[LAST] = w_valid[LAST] & out_ready;
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            w_adv[k] = w_valid[k] & (~w_valid[k+1] | w_adv[k+1]);
        end
    end

    assign w_load     = ~w_valid | w_adv;
    assign in_ready   = w_load[0];
    assign w_accept   = in_valid & in_ready & ~flush;
    assign out_valid  = w_valid[LAST];
    assign out_result = w_res_flat[LAST*XLEN +: XLEN];
    assign out_rd     = byp_rd[LAST*RW +: RW];
    assign byp_valid  = w_valid;

    genvar i;
    generate
        for (i = 0; i < STAGES; i++) begin : gen_slot
            logic            r_valid;
            logic [XLEN-1:0] r_result;
            logic [RW-1:0]   r_rd;
            logic            w_fill;
            logic [XLEN-1:0] w_d_result;
            logic [RW-1:0]   w_d_rd;

            if (i == 0) begin : gen_head
                assign w_fill     = w_accept;
                assign w_d_result = w_alu;
                assign w_d_rd     = in_rd;
            end else begin : gen_body
                assign w_fill     = w_valid[i-1];
                assign w_d_result = w_res_flat[(i-1)*XLEN +: XLEN];
                assign w_d_rd     = byp_rd[(i-1)*RW +: RW];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                end else if (flush) begin
                    r_valid <= 1'b0;
                end else if (w_load[i]) begin
                    r_valid <= w_fill;
                end
            end

            // Payload has no reset; it only matters while r_valid is set.
            always_ff @(posedge clk) begin
                if (w_load[i] && w_fill) begin
                    r_result <= w_d_result;
                    r_rd     <= w_d_rd;
                end
            end

            assign w_valid[i]                 = r_valid;
            assign w_res_flat[i*XLEN +: XLEN] = r_result;
            assign byp_rd[i*RW +: RW]         = r_rd;
        end
    endgenerate

endmodule

// File: tb/tb_riscv_alu_pipe.sv
// Directed bench: 32-bit/3-stage instance for ALU vectors, backpressure,
// bubble collapse and flush; 64-bit/1-stage instance for async reset.
module tb_riscv_alu_pipe;
    import riscv_alu_pkg::*;

    logic clk;
    int   n_cmp = 0;
    int   n_bad = 0;

    // 32-bit, 3-stage instance
    logic        rst_n_a, in_valid_a, in_ready_a, in_use_imm_a, flush_a;
    logic        out_valid_a, out_ready_a;
    logic [31:0] in_rs1_a, in_rs2_a, in_imm_a, out_result_a;
    logic [3:0]  in_alu_op_a;
    logic [4:0]  in_rd_a, out_rd_a;
    logic [2:0]  byp_valid_a;
    logic [14:0] byp_rd_a;

    // 64-bit, 1-stage instance
    logic        rst_n_b, in_valid_b, in_ready_b, in_use_imm_b, flush_b;
    logic        out_valid_b, out_ready_b;
    logic [63:0] in_rs1_b, in_rs2_b, in_imm_b, out_result_b;
    logic [3:0]  in_alu_op_b;
    logic [4:0]  in_rd_b, out_rd_b;
    logic [0:0]  byp_valid_b;
    logic [4:0]  byp_rd_b;

    riscv_alu_pipe #(.XLEN(32), .STAGES(3), .RW(5)) u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_rs1(in_rs1_a), .in_rs2(in_rs2_a), .in_imm(in_imm_a), .in_use_imm(in_use_imm_a),
        .in_alu_op(in_alu_op_a), .in_rd(in_rd_a), .flush(flush_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_result(out_result_a),
        .out_rd(out_rd_a), .byp_valid(byp_valid_a), .byp_rd(byp_rd_a)
    );

    riscv_alu_pipe #(.XLEN(64), .STAGES(1), .RW(5)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_rs1(in_rs1_b), .in_rs2(in_rs2_b), .in_imm(in_imm_b), .in_use_imm(in_use_imm_b),
        .in_alu_op(in_alu_op_b), .in_rd(in_rd_b), .flush(flush_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_result(out_result_b),
        .out_rd(out_rd_b), .byp_valid(byp_valid_b), .byp_rd(byp_rd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        alu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        use_imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input alu_op_e op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] imm,
                           input logic ui, input logic [4:0] rd);
        in_valid_a   = v;
        in_alu_op_a  = op;
        in_rs1_a     = a;
        in_rs2_a     = b;
        in_imm_a     = imm;
        in_use_imm_a = ui;
        in_rd_a      = rd;
    endtask

    initial begin
        vecs[0]  = '{"add",      ALU_ADD,    32'd5,          32'd7,          32'd0,    1'b0, 32'd12};
        vecs[1]  = '{"sub",      ALU_SUB,    32'd3,          32'd5,          32'd0,    1'b0, 32'hFFFF_FFFE};
        vecs[2]  = '{"and",      ALU_AND,    32'hF0F0_1234,  32'h0FF0_FF00,  32'd0,    1'b0, 32'h00F0_1200};
        vecs[3]  = '{"or",       ALU_OR,     32'hF0F0_1234,  32'h0FF0_FF00,  32'd0,    1'b0, 32'hFFF0_FF34};
        vecs[4]  = '{"xor",      ALU_XOR,    32'hF0F0_1234,  32'h0FF0_FF00,  32'd0,    1'b0, 32'hFF00_ED34};
        vecs[5]  = '{"sll_imm",  ALU_SLL,    32'd1,          32'd9,          32'h21,   1'b1, 32'd2};
        vecs[6]  = '{"srl",      ALU_SRL,    32'h8000_0000,  32'd31,         32'd0,    1'b0, 32'd1};
        vecs[7]  = '{"sra_imm",  ALU_SRA,    32'h8000_0000,  32'd0,          32'h24,   1'b1, 32'hF800_0000};
        vecs[8]  = '{"sltu",     ALU_SLTU,   32'd1,          32'hFFFF_FFFF,  32'd0,    1'b0, 32'd1};
        vecs[9]  = '{"slt",      ALU_SLT,    32'd1,          32'hFFFF_FFFF,  32'd0,    1'b0, 32'd0};
        vecs[10] = '{"slt_neg",  ALU_SLT,    32'hFFFF_FFFF,  32'd1,          32'd0,    1'b0, 32'd1};
        vecs[11] = '{"pass_a",   ALU_PASS_A, 32'hDEAD_BEEF,  32'd4,          32'd0,    1'b0, 32'hDEAD_BEEF};
        vecs[12] = '{"pass_b",   ALU_PASS_B, 32'd0,          32'h999,        32'h123,  1'b1, 32'h123};
        vecs[13] = '{"rsv_e",    ALU_RSV_E,  32'h55,         32'h66,         32'd0,    1'b0, 32'h55};
        vecs[14] = '{"add_wrap", ALU_ADD,    32'hFFFF_FFFF,  32'd2,          32'd0,    1'b0, 32'd1};

        rst_n_a = 1'b0; rst_n_b = 1'b0;
        flush_a = 1'b0; flush_b = 1'b0;
        out_ready_a = 1'b1; out_ready_b = 1'b1;
        drive_a(1'b0, ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        in_valid_b = 1'b0; in_alu_op_b = 4'd0; in_rs1_b = '0; in_rs2_b = '0;
        in_imm_b = '0; in_use_imm_b = 1'b0; in_rd_b = '0;
        #12;
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        tick();

        check("reset_out_valid", 64'(out_valid_a), 64'd0);
        check("reset_byp_valid", 64'(byp_valid_a), 64'd0);
        check("reset_in_ready",  64'(in_ready_a),  64'd1);

        // Streaming vectors, one per cycle; results emerge two edges later.
        for (int t = 0; t < 17; t++) begin
            if (t < 15)
                drive_a(1'b1, vecs[t].op, vecs[t].a, vecs[t].b, vecs[t].imm,
                        vecs[t].use_imm, 5'(t + 1));
            else
                drive_a(1'b0, ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
            check("stream_in_ready", 64'(in_ready_a), 64'd1);
            tick();
            if (t >= 2) begin
                check({vecs[t-2].name, "_valid"}, 64'(out_valid_a), 64'd1);
                check(vecs[t-2].name, 64'(out_result_a), 64'(vecs[t-2].exp));
                check({vecs[t-2].name, "_rd"}, 64'(out_rd_a), 64'(t - 1));
            end
        end
        tick();
        check("drained", 64'(out_valid_a), 64'd0);

        // Backpressure: fill three slots with the consumer stalled.
        out_ready_a = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive_a(1'b1, ALU_ADD, 32'(k), 32'(k), 32'd0, 1'b0, 5'(k + 20));
            check("bp_fill_ready", 64'(in_ready_a), 64'd1);
            tick();
        end
        drive_a(1'b0, ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        check("bp_full_ready",  64'(in_ready_a),   64'd0);
        check("bp_byp_full",    64'(byp_valid_a),  64'b111);
        check("bp_out_first",   64'(out_result_a), 64'd2);
        tick();
        check("bp_hold_result", 64'(out_result_a), 64'd2);
        check("bp_hold_rd",     64'(out_rd_a),     64'd21);
        check("bp_hold_ready",  64'(in_ready_a),   64'd0);
        out_ready_a = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready_a), 64'd1);
        tick();
        check("bp_drain2", 64'(out_result_a), 64'd4);
        check("bp_drain2_v", 64'(out_valid_a), 64'd1);
        tick();
        check("bp_drain3", 64'(out_result_a), 64'd6);
        check("bp_drain3_rd", 64'(out_rd_a), 64'd23);
        tick();
        check("bp_empty", 64'(out_valid_a), 64'd0);

        // Bubble collapse under a stalled consumer.
        out_ready_a = 1'b0;
        drive_a(1'b1, ALU_ADD, 32'd10, 32'd1, 32'd0, 1'b0, 5'd1);
        tick();
        check("bub_001", 64'(byp_valid_a), 64'b001);
        drive_a(1'b0, ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        tick();
        check("bub_010", 64'(byp_valid_a), 64'b010);
        drive_a(1'b1, ALU_ADD, 32'd20, 32'd2, 32'd0, 1'b0, 5'd2);
        tick();
        check("bub_101", 64'(byp_valid_a), 64'b101);
        drive_a(1'b0, ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        tick();
        check("bub_110", 64'(byp_valid_a), 64'b110);
        check("bub_byp_rd", 64'(byp_rd_a[14:5]), 64'({5'd1, 5'd2}));
        tick();
        check("bub_110_hold", 64'(byp_valid_a), 64'b110);
        check("bub_out_a", 64'(out_result_a), 64'd11);

        // Flush with all three slots valid and an input presented.
        drive_a(1'b1, ALU_ADD, 32'd30, 32'd3, 32'd0, 1'b0, 5'd3);
        tick();
        check("fl_pre_full", 64'(byp_valid_a), 64'b111);
        drive_a(1'b1, ALU_ADD, 32'd40, 32'd4, 32'd0, 1'b0, 5'd4);
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        drive_a(1'b0, ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        check("fl_byp", 64'(byp_valid_a), 64'b000);
        check("fl_out_valid", 64'(out_valid_a), 64'd0);
        tick();
        check("fl_input_dropped", 64'(byp_valid_a), 64'b000);

        // 64-bit, single stage: async reset during a stall.
        out_ready_b  = 1'b0;
        in_valid_b   = 1'b1;
        in_alu_op_b  = 4'(ALU_ADD);
        in_rs1_b     = 64'd1;
        in_rs2_b     = 64'd2;
        in_rd_b      = 5'd3;
        tick();
        in_valid_b = 1'b0;
        check("b_lat1_valid", 64'(out_valid_b), 64'd1);
        check("b_lat1_result", out_result_b, 64'd3);
        check("b_stall_ready", 64'(in_ready_b), 64'd0);
        #2;
        rst_n_b = 1'b0;
        #1;
        check("b_async_out_valid", 64'(out_valid_b), 64'd0);
        check("b_async_byp", 64'(byp_valid_b), 64'd0);
        check("b_async_in_ready", 64'(in_ready_b), 64'd1);
        tick();
        #2;
        rst_n_b = 1'b1;
        out_ready_b = 1'b1;
        check("b_post_in_ready", 64'(in_ready_b), 64'd1);
        in_valid_b   = 1'b1;
        in_alu_op_b  = 4'(ALU_SLL);
        in_rs1_b     = 64'd1;
        in_rs2_b     = 64'h0000_0000_0000_00FF;
        in_use_imm_b = 1'b0;
        in_rd_b      = 5'd9;
        tick();
        in_valid_b = 1'b0;
        check("b_sll63_valid", 64'(out_valid_b), 64'd1);
        check("b_sll63", out_result_b, 64'h8000_0000_0000_0000);
        check("b_sll63_rd", 64'(out_rd_b), 64'd9);
        tick();
        check("b_drained", 64'(out_valid_b), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
